dp_skid_stage: RTL and testbench
================================

Name: dp_skid_stage

Overview:
- Elastic pipeline register for the datapath, carrying the same payload triple as the fixed stage registers (two WIDTH data words plus one WIDTH1 tag).
- Sits at the consuming end of a stage boundary. Decouples the producer stage from a downstream stage that can back-pressure, e.g. a multi-cycle execute unit.
- Valid/ready handshake on both sides, 2-entry skid buffer, synchronous flush.
- Full throughput; no combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 32, width of data payloads d0/d1 and q0/q1.
- WIDTH1, 4, width of tag payload d2/q2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; asserting reset=0 clears all state immediately.
- flush  input  1  synchronous; discards all buffered entries.
- in_valid  input  1  producer presents d0/d1/d2.
- in_ready  output  1  stage can accept this cycle; driven directly from a flop.
- d0  input  WIDTH  data payload 0.
- d1  input  WIDTH  data payload 1.
- d2  input  WIDTH1  tag payload.
- out_valid  output  1  q0/q1/q2 hold a valid entry.
- out_ready  input  1  consumer accepts this cycle.
- q0  output  WIDTH  data payload 0.
- q1  output  WIDTH  data payload 1.
- q2  output  WIDTH1  tag payload.
- stall_cnt  output  16  present only with DP_SKID_STATS_EN.

Behaviour:
- Handshakes:
  - Transfer in = in_valid & in_ready.
  - Transfer out = out_valid & out_ready.
  - Both evaluated at the rising edge of clk.
- Storage:
  - Main entry drives q0/q1/q2/out_valid.
  - Skid entry holds one overflow payload.
- States, encoding in shared package:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Outputs per state:
  - in_ready = 1 in EMPTY and ONE, 0 in FULL.
  - out_valid = 1 in ONE and FULL.
- Transitions, with no flush:
  - EMPTY + in -> ONE; payload loads main.
  - ONE + in + out -> ONE; main reloads with new payload (pass-through, 1 transfer/cycle).
  - ONE + in, no out -> FULL; payload loads skid.
  - ONE + out, no in -> EMPTY.
  - FULL + out -> ONE; skid moves to main.
  - FULL never accepts input.
  - All other cases hold state.
- Latency:
  - 1 cycle from input acceptance to out_valid when EMPTY.
  - Data ordering is strictly FIFO.
- Payload stability:
  - q0/q1/q2 never change while out_valid=1 and out_ready=0.
  - When EMPTY, q outputs hold their last value; don't-care for the consumer.
- Flush:
  - At the edge, state -> EMPTY. Any same-cycle input and output transfers are discarded; in_ready returns 1 the following cycle.
  - Payload registers are not cleared.
- Reset (reset=0):
  - State EMPTY, in_ready=0 while reset is asserted, in_ready=1 after deassertion.
  - out_valid=0, q0=0, q1=0, q2=0, stall_cnt=0.
  - Reset mid-transfer drops all entries.
- Widths: payload copied bit-exact; no arithmetic.

Optional Feature:
- Macro DP_SKID_STATS_EN.
- Defined:
  - Port stall_cnt exists.
  - Increments by 1 each cycle with out_valid=1 & out_ready=0.
  - Saturates at 16'hFFFF.
  - Cleared by reset only, not by flush.
- Undefined: port and counter are absent; behaviour otherwise identical.

Decomposition:
- Shared package dp_pipe_pkg holds:
  - the state enum skid_state_t (EMPTY/ONE/FULL);
  - default width constants DP_WIDTH=32 and DP_TAG_WIDTH=4;
  - the packed payload struct dp_payload_t {d0, d1, d2}.
- Sub-module dp_payload_reg: one enable-loaded payload register with async active-low clear. Instantiated twice (main, skid).

Test Plan:
- Reset then idle: reset=0 for 2 cycles -> out_valid=0, q0=q1=0, q2=0, in_ready=0 during reset; in_ready=1 the cycle after release.
- Streaming with out_ready=1: send d0=1..8, d1=d0+100, d2=d0[3:0], one per cycle -> same sequence appears one cycle later, no bubbles, in_ready stays 1.
- Back-pressure:
  - Send A=0x11, B=0x22, then hold out_ready=0 -> FULL, in_ready=0, q0 holds 0x11.
  - Release out_ready -> 0x11 then 0x22 in order, in_ready returns 1 one cycle after the first transfer out.
- Flush in FULL, with in_valid=1 (d0=0x33) and out_ready=1 in the same cycle -> next cycle out_valid=0, in_ready=1; 0x33 never appears at the output.
- Async reset mid-stream: drop reset between clock edges while FULL -> out_valid=0 and q outputs 0 immediately, without waiting for a clock edge.
- With DP_SKID_STATS_EN: hold out_valid=1, out_ready=0 for 5 cycles -> stall_cnt=5; flush -> stall_cnt stays 5; force saturation -> stays 16'hFFFF.

Source files
------------

// File: rtl/dp_pipe_pkg.sv
// dp_pipe_pkg: shared definitions for the datapath pipeline stages.
//   skid_state_t  - occupancy state of the elastic skid stage (EMPTY/ONE/FULL)
//   DP_WIDTH      - default width of the data payload words d0/d1
//   DP_TAG_WIDTH  - default width of the tag payload d2
//   dp_payload_t  - packed payload triple {d0, d1, d2} at the default widths
package dp_pipe_pkg;

   localparam int DP_WIDTH     = 32;
   localparam int DP_TAG_WIDTH = 4;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,   // main invalid, skid invalid
      ONE   = 2'b01,   // main valid, skid invalid
      FULL  = 2'b10    // main valid, skid valid
   } skid_state_t;

   typedef struct packed {
      logic [DP_WIDTH-1:0]     d0;
      logic [DP_WIDTH-1:0]     d1;
      logic [DP_TAG_WIDTH-1:0] d2;
   } dp_payload_t;

endpackage : dp_pipe_pkg

// File: rtl/dp_payload_reg.sv
// dp_payload_reg: one payload register, loaded when 'load' is high and
// cleared asynchronously to zero while rst_n is low.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low clear
//   load  - capture d on the next rising edge
//   d     - payload to capture (flattened payload triple)
//   q     - stored payload
module dp_payload_reg #(
   parameter int W = 68
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   // Payload storage: cleared by reset, otherwise loaded on enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= {W{1'b0}};
      end else if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule : dp_payload_reg

// File: rtl/dp_skid_stage.sv
// dp_skid_stage: elastic pipeline register with a 2-entry skid buffer.
// Carries the payload triple {d0, d1, d2} from a producer to a consumer that
// may back-pressure. Full throughput; in_ready comes straight from a flop so
// there is no combinational path from out_ready to in_ready.
//
// Optional build macro: DP_SKID_STATS_EN adds the stall_cnt port, a 16-bit
// saturating count of cycles with out_valid=1 and out_ready=0 (reset-only clear).
//
// Ports:
//   clk        - rising-edge clock
//   reset      - asynchronous active-low reset, clears all state
//   flush      - synchronous flush, discards all buffered entries
//   in_valid   - producer presents d0/d1/d2
//   in_ready   - stage can accept this cycle (registered)
//   d0, d1     - data payload inputs (WIDTH)
//   d2         - tag payload input (WIDTH1)
//   out_valid  - q0/q1/q2 hold a valid entry (registered)
//   out_ready  - consumer accepts this cycle
//   q0, q1, q2 - payload outputs, driven directly by the main entry register
//   stall_cnt  - stall cycle counter (DP_SKID_STATS_EN only)
module dp_skid_stage
   import dp_pipe_pkg::*;
#(
   parameter int WIDTH  = DP_WIDTH,
   parameter int WIDTH1 = DP_TAG_WIDTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  d0,
   input  logic [WIDTH-1:0]  d1,
   input  logic [WIDTH1-1:0] d2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  q0,
   output logic [WIDTH-1:0]  q1,
   output logic [WIDTH1-1:0] q2
`ifdef DP_SKID_STATS_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   localparam int PW = 2 * WIDTH + WIDTH1;

   skid_state_t   state;
   logic          in_xfer;
   logic          out_xfer;
   logic          main_load;
   logic          skid_load;
   logic [PW-1:0] in_word;
   logic [PW-1:0] main_next;
   logic [PW-1:0] main_word;
   logic [PW-1:0] skid_word;

   assign in_word      = {d0, d1, d2};
   assign {q0, q1, q2} = main_word;

   // Handshake qualifiers seen at the coming rising edge.
   always_comb begin
      in_xfer  = in_valid & in_ready;
      out_xfer = out_valid & out_ready;
   end

   // Payload steering: which register loads and from where. Flush blocks all
   // loads so discarded input never reaches the payload registers.
   always_comb begin
      main_load = 1'b0;
      skid_load = 1'b0;
      main_next = in_word;
      if (flush) begin
         main_load = 1'b0;
         skid_load = 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               main_load = in_xfer;
            end
            ONE: begin
               // Pass-through when both sides move; otherwise overflow to skid.
               main_load = in_xfer & out_xfer;
               skid_load = in_xfer & ~out_xfer;
            end
            FULL: begin
               // Skid entry advances into main once main drains.
               main_load = out_xfer;
               main_next = skid_word;
            end
            default: begin
               main_load = 1'b0;
               skid_load = 1'b0;
            end
         endcase
      end
   end

   dp_payload_reg #(.W(PW)) u_main (
      .clk   (clk),
      .rst_n (reset),
      .load  (main_load),
      .d     (main_next),
      .q     (main_word)
   );

   dp_payload_reg #(.W(PW)) u_skid (
      .clk   (clk),
      .rst_n (reset),
      .load  (skid_load),
      .d     (in_word),
      .q     (skid_word)
   );

   // Occupancy FSM with registered in_ready/out_valid. in_ready is held low
   // through reset and rises on the first edge after release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= EMPTY;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         state     <= EMPTY;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            EMPTY: begin
               in_ready <= 1'b1;
               if (in_xfer) begin
                  state     <= ONE;
                  out_valid <= 1'b1;
               end else begin
                  state     <= EMPTY;
                  out_valid <= 1'b0;
               end
            end
            ONE: begin
               if (in_xfer && !out_xfer) begin
                  state     <= FULL;
                  in_ready  <= 1'b0;
                  out_valid <= 1'b1;
               end else if (out_xfer && !in_xfer) begin
                  state     <= EMPTY;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
               end else begin
                  state     <= ONE;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b1;
               end
            end
            FULL: begin
               out_valid <= 1'b1;
               if (out_xfer) begin
                  state    <= ONE;
                  in_ready <= 1'b1;
               end else begin
                  state    <= FULL;
                  in_ready <= 1'b0;
               end
            end
            default: begin
               state     <= EMPTY;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef DP_SKID_STATS_EN
   // Saturating stall counter; flush deliberately leaves it untouched.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt <= 16'h0000;
      end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'h0001;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end
`endif

endmodule : dp_skid_stage

// File: tb/tb_dp_skid_stage.sv
// tb_dp_skid_stage: self-checking bench for dp_skid_stage. Accepted inputs are
// pushed to a scoreboard queue and popped/compared when an output transfer
// happens. Inputs change 1 time unit after the rising edge; the scoreboard
// samples on the falling edge.
module tb_dp_skid_stage;
   import dp_pipe_pkg::*;

   logic                    clk = 1'b0;
   logic                    reset;
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [DP_WIDTH-1:0]     d0;
   logic [DP_WIDTH-1:0]     d1;
   logic [DP_TAG_WIDTH-1:0] d2;
   logic                    out_valid;
   logic                    out_ready;
   logic [DP_WIDTH-1:0]     q0;
   logic [DP_WIDTH-1:0]     q1;
   logic [DP_TAG_WIDTH-1:0] q2;
`ifdef DP_SKID_STATS_EN
   logic [15:0]             stall_cnt;
`endif

   int          n_checks = 0;
   int          n_errors = 0;
   dp_payload_t sb[$];
   dp_payload_t exp_p;
   dp_payload_t push_p;
   logic        seen33 = 1'b0;

   always #5 clk = ~clk;

   dp_skid_stage dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .q0        (q0),
      .q1        (q1),
      .q2        (q2)
`ifdef DP_SKID_STATS_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   task automatic check_val(input string tag, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
      in_valid = v;
      d0 = a;
      d1 = b;
      d2 = t;
   endtask

   // Scoreboard: pop on output transfer, push on input transfer; reset and
   // flush discard everything buffered, including same-cycle transfers.
   always @(negedge clk) begin
      if (!reset || flush) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            check_val("sb_nonempty", 96'(sb.size() != 0), 96'd1);
            if (sb.size() != 0) begin
               exp_p = sb.pop_front();
               check_val("sb_data", 96'({q0, q1, q2}), 96'(exp_p));
            end
         end
         if (in_valid && in_ready) begin
            push_p.d0 = d0;
            push_p.d1 = d1;
            push_p.d2 = d2;
            sb.push_back(push_p);
         end
      end
      if (reset && out_valid && q0 == 32'h33) seen33 = 1'b1;
   end

   initial begin
      reset = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0);

      // Reset then idle.
      tick();
      tick();
      check_val("rst_out_valid", 96'(out_valid), 96'd0);
      check_val("rst_q0", 96'(q0), 96'd0);
      check_val("rst_q1", 96'(q1), 96'd0);
      check_val("rst_q2", 96'(q2), 96'd0);
      check_val("rst_in_ready", 96'(in_ready), 96'd0);
`ifdef DP_SKID_STATS_EN
      check_val("rst_stall_cnt", 96'(stall_cnt), 96'd0);
`endif
      reset = 1'b1;
      tick();
      check_val("post_rst_in_ready", 96'(in_ready), 96'd1);

      // Streaming, out_ready held high: one transfer per cycle, 1-cycle latency.
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 32'(i), 32'(i + 100), 4'(i));
         tick();
         check_val("stream_in_ready", 96'(in_ready), 96'd1);
         check_val("stream_out_valid", 96'(out_valid), 96'd1);
         check_val("stream_q0", 96'(q0), 96'(i));
      end
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      tick();
      check_val("stream_drain_valid", 96'(out_valid), 96'd0);

      // Back-pressure: A then B with the consumer stalled.
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 32'h1111, 4'h1);
      tick();
      drive(1'b1, 32'h22, 32'h2222, 4'h2);
      tick();
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("bp_in_ready", 96'(in_ready), 96'd0);
         check_val("bp_out_valid", 96'(out_valid), 96'd1);
         check_val("bp_q_hold", 96'({q0, q1, q2}), 96'({32'h11, 32'h1111, 4'h1}));
      end
      out_ready = 1'b1;
      tick();
      check_val("bp_rel_in_ready", 96'(in_ready), 96'd1);
      check_val("bp_rel_q0", 96'(q0), 96'h22);
      tick();
      check_val("bp_empty_valid", 96'(out_valid), 96'd0);

      // Flush while FULL with same-cycle input and output transfers.
      out_ready = 1'b0;
      drive(1'b1, 32'h44, 32'h4444, 4'h4);
      tick();
      drive(1'b1, 32'h55, 32'h5555, 4'h5);
      tick();
      check_val("fl_full_in_ready", 96'(in_ready), 96'd0);
      flush = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h33, 32'h3333, 4'h3);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      check_val("fl_out_valid", 96'(out_valid), 96'd0);
      check_val("fl_in_ready", 96'(in_ready), 96'd1);
      tick();
      tick();
      check_val("fl_still_empty", 96'(out_valid), 96'd0);

      // Asynchronous reset between edges while FULL.
      out_ready = 1'b0;
      drive(1'b1, 32'h66, 32'h6666, 4'h6);
      tick();
      drive(1'b1, 32'h77, 32'h7777, 4'h7);
      tick();
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      check_val("ar_full_valid", 96'(out_valid), 96'd1);
      #2;
      reset = 1'b0;
      #1;
      check_val("ar_out_valid", 96'(out_valid), 96'd0);
      check_val("ar_q", 96'({q0, q1, q2}), 96'd0);
      check_val("ar_in_ready", 96'(in_ready), 96'd0);
      tick();
      reset = 1'b1;
      tick();
      check_val("ar_rel_in_ready", 96'(in_ready), 96'd1);
      check_val("ar_rel_valid", 96'(out_valid), 96'd0);

`ifdef DP_SKID_STATS_EN
      check_val("st_zero", 96'(stall_cnt), 96'd0);
      out_ready = 1'b0;
      drive(1'b1, 32'h88, 32'h8888, 4'h8);
      tick();
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 5; i++) tick();
      check_val("st_five", 96'(stall_cnt), 96'd5);
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
      check_val("st_after_flush", 96'(stall_cnt), 96'd5);
      out_ready = 1'b0;
      drive(1'b1, 32'h99, 32'h9999, 4'h9);
      tick();
      drive(1'b0, 32'h0, 32'h0, 4'h0);
      for (int i = 0; i < 65535; i++) tick();
      check_val("st_sat", 96'(stall_cnt), 96'hFFFF);
      tick();
      tick();
      check_val("st_sat_hold", 96'(stall_cnt), 96'hFFFF);
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      flush = 1'b0;
`endif

      // Drain check: nothing left outstanding and the flushed word never left.
      tick();
      check_val("sb_drain", 96'(sb.size()), 96'd0);
      check_val("flushed_word_absent", 96'(seen33), 96'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_dp_skid_stage
